// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared bus encodings, FSM states and lane decode for the AHB-Lite memory slave
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } slave_state_e;

  // Lane mask for an aligned, legal transfer; size 2'd3 never reaches here.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    byte_enables = 4'b0001 << lane;
      2'd1:    byte_enables = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - word RAM with synchronous byte-enabled write and asynchronous read
module ahb_slave_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_slave.sv
// rtl/ahb_lite_slave.sv - sole AHB-Lite slave: memory target with wait states and two-cycle ERROR
module ahb_lite_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP
);

  localparam int                IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH * 4);
  localparam logic [3:0]        WAIT_LOAD  = 4'(WAIT_STATES);

  slave_state_e     state_q, state_d;
  logic [IDX_W+1:0] addr_q;
  logic             write_q;
  logic [1:0]       size_q;
  logic [3:0]       wait_q;
  logic             accept;
  logic             xfer_err;
  logic [31:0]      mem_rdata;

  assign accept = HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

  always_comb begin
    xfer_err = 1'b0;
    if (HADDR >= ADDR_LIMIT)                      xfer_err = 1'b1;
    if (HSIZE > HSIZE_WORD)                       xfer_err = 1'b1;
    if (HSIZE == HSIZE_HALF && HADDR[0])          xfer_err = 1'b1;
    if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) xfer_err = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      wait_q  <= 4'd0;
    end else if (accept) begin
      addr_q  <= HADDR[IDX_W+1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE[1:0];
      wait_q  <= WAIT_LOAD;
    end else if (state_q == S_WAIT) begin
      wait_q  <= wait_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (wait_q == 4'd1) state_d = S_LAST;
      S_ERR1:  state_d = S_ERR2;
      // IDLE, LAST and ERR2 all sample the next address phase
      default: begin
        if (!accept)              state_d = S_IDLE;
        else if (xfer_err)        state_d = S_ERR1;
        else if (WAIT_STATES > 0) state_d = S_WAIT;
        else                      state_d = S_LAST;
      end
    endcase
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    case (state_q)
      S_WAIT:  HREADY = 1'b0;
      S_ERR1:  begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
      end
      S_ERR2:  HRESP = HRESP_ERROR;
      default: ;
    endcase
    HRDATA = ((state_q == S_WAIT || state_q == S_LAST) && !write_q) ? mem_rdata : '0;
  end

  ahb_slave_mem #(
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .HCLK  (HCLK),
    .we    (state_q == S_LAST && write_q),
    .be    (byte_enables(size_q, addr_q[1:0])),
    .addr  (addr_q[IDX_W+1:2]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_lite_slave.sv
// tb/tb_ahb_lite_slave.sv - scoreboard bench for ahb_lite_slave at zero and two wait states
module tb_ahb_lite_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        sel;
  logic [1:0]  htrans0, htrans2;
  logic [31:0] hrdata0, hrdata2;
  logic        hready0, hready2, hresp0, hresp2;

  always #5 HCLK = ~HCLK;

  assign htrans0 = sel ? 2'b00 : htrans;
  assign htrans2 = sel ? htrans : 2'b00;

  ahb_lite_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans0), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
  );

  ahb_lite_slave #(.WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans2), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2)
  );

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    int          id;
    logic        err;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  xfer_t       xq[$];
  exp_t        sb[$];
  logic [31:0] ref_mem [2][256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          next_id  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] t, input logic w, input logic [31:0] a,
                     input logic [2:0] s, input logic [31:0] d);
    xfer_t x;
    x.trans = t;
    x.write = w;
    x.addr  = a;
    x.size  = s;
    x.wdata = d;
    xq.push_back(x);
  endtask

  // Drive an address phase and push what its data phase must show.
  task automatic present(input xfer_t x);
    exp_t       e;
    logic       err;
    logic [3:0] be;
    int         idx, bank;
    htrans  = x.trans;
    hwrite  = x.write;
    haddr   = x.addr;
    hsize   = x.size;
    bank    = sel ? 1 : 0;
    e.id    = next_id;
    next_id++;
    e.wdata = x.wdata;
    e.err   = 1'b0;
    e.waits = 0;
    e.rdata = 32'h0;
    if (x.trans == 2'b10 || x.trans == 2'b11) begin
      err = (x.addr >= 32'h400) || (x.size > 3'd2) ||
            (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'b00);
      idx = int'(x.addr[9:2]);
      if (err) begin
        e.err   = 1'b1;
        e.waits = 1;
      end else begin
        e.waits = sel ? 2 : 0;
        if (x.write) begin
          case (x.size)
            3'd0:    be = 4'b0001 << x.addr[1:0];
            3'd1:    be = x.addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
          endcase
          for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[bank][idx][8*i +: 8] = x.wdata[8*i +: 8];
        end else begin
          e.rdata = ref_mem[bank][idx];
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic run_seq();
    int          guard = 0;
    int          waits = 0;
    exp_t        e;
    logic        rdy, rsp;
    logic [31:0] rd;
    while ((xq.size() > 0 || sb.size() > 0) && guard < 200) begin
      @(negedge HCLK);
      guard++;
      rdy = sel ? hready2 : hready0;
      rsp = sel ? hresp2  : hresp0;
      rd  = sel ? hrdata2 : hrdata0;
      if (sb.size() > 0) hwdata = sb[0].wdata;
      if (!rdy) begin
        waits++;
        if (sb.size() > 0)
          check_eq($sformatf("x%0d_wait_resp", sb[0].id), 32'(rsp), 32'(sb[0].err));
        else
          check_eq("spurious_wait", 32'(rdy), 32'd1);
      end else begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq($sformatf("x%0d_resp", e.id),  32'(rsp), 32'(e.err));
          check_eq($sformatf("x%0d_waits", e.id), 32'(waits), 32'(e.waits));
          check_eq($sformatf("x%0d_rdata", e.id), rd, e.rdata);
        end
        waits = 0;
        if (xq.size() > 0) present(xq.pop_front());
        else begin
          htrans = 2'b00;
          hwrite = 1'b0;
        end
      end
    end
    if (guard >= 200) begin
      check_eq("run_seq_timeout", 32'(guard), 32'd0);
      xq.delete();
      sb.delete();
    end
  endtask

  initial begin
    sel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'd0; hwdata = '0;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    check_eq("rst_hready0", 32'(hready0), 32'd1);
    check_eq("rst_hresp0",  32'(hresp0),  32'd0);
    check_eq("rst_hrdata0", hrdata0,      32'd0);
    check_eq("rst_hready2", 32'(hready2), 32'd1);
    check_eq("rst_hresp2",  32'(hresp2),  32'd0);
    check_eq("rst_hrdata2", hrdata2,      32'd0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    check_eq("rel_hready0", 32'(hready0), 32'd1);
    check_eq("rel_hresp0",  32'(hresp0),  32'd0);
    check_eq("rel_hrdata0", hrdata0,      32'd0);

    add(2'b10, 1, 32'h010, 3'd2, 32'hDEADBEEF);
    add(2'b10, 0, 32'h010, 3'd2, 32'h0);
    add(2'b10, 1, 32'h020, 3'd2, 32'h00000000);
    add(2'b10, 1, 32'h021, 3'd0, 32'h00001100);
    add(2'b11, 1, 32'h023, 3'd0, 32'h22000000);
    add(2'b10, 0, 32'h020, 3'd2, 32'h0);
    add(2'b10, 1, 32'h022, 3'd1, 32'hABCD0000);
    add(2'b10, 0, 32'h020, 3'd2, 32'h0);
    add(2'b10, 1, 32'h000, 3'd2, 32'h01020304);
    add(2'b10, 1, 32'h3FC, 3'd2, 32'h55AA55AA);
    add(2'b10, 0, 32'h3FC, 3'd2, 32'h0);
    add(2'b10, 1, 32'h400, 3'd2, 32'hFFFFFFFF);
    add(2'b10, 1, 32'h002, 3'd2, 32'hFFFFFFFF);
    add(2'b10, 1, 32'h010, 3'd3, 32'hFFFFFFFF);
    add(2'b10, 1, 32'h021, 3'd1, 32'hFFFFFFFF);
    add(2'b10, 0, 32'h400, 3'd2, 32'h0);
    add(2'b10, 0, 32'h000, 3'd2, 32'h0);
    add(2'b10, 0, 32'h010, 3'd2, 32'h0);
    add(2'b10, 0, 32'h020, 3'd2, 32'h0);
    add(2'b10, 0, 32'h3FC, 3'd2, 32'h0);
    add(2'b01, 1, 32'h010, 3'd2, 32'h0BAD0BAD);
    add(2'b00, 1, 32'h010, 3'd2, 32'h0BAD0BAD);
    add(2'b10, 0, 32'h010, 3'd2, 32'h0);
    run_seq();

    sel = 1'b1;
    add(2'b10, 1, 32'h000, 3'd2, 32'h600DF00D);
    add(2'b10, 0, 32'h000, 3'd2, 32'h0);
    add(2'b10, 1, 32'h404, 3'd2, 32'hFFFFFFFF);
    add(2'b10, 1, 32'h040, 3'd2, 32'hCAFEF00D);
    add(2'b10, 0, 32'h040, 3'd2, 32'h0);
    run_seq();

    @(negedge HCLK);
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h040; hsize = 3'd2;
    @(negedge HCLK);
    hwdata = 32'h12345678; htrans = 2'b00; hwrite = 1'b0;
    check_eq("abort_in_wait", 32'(hready2), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("abort_hready", 32'(hready2), 32'd1);
    check_eq("abort_hresp",  32'(hresp2),  32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    add(2'b10, 0, 32'h040, 3'd2, 32'h0);
    run_seq();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
